cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares the single cache port of the harp core cache test system between the instruction-fetch
//  (I) and load/store (D) requesters. Arbitrates round-robin, latches the winning request and holds
//  it on the cache port until the cache answers, then routes read data back as a one-cycle valid.
//  A watchdog aborts transactions the cache never answers.
// PARAMETERS
//  AW       32   address width, bits
//  DW       32   data width, bits
//  TIMEOUT  255  max cycles in BUSY before abort; 0 disables watchdog; counter width $clog2(TIMEOUT+1)
// PORTS
//  phi       in   1   system clock, all state on rising edge
//  reset_in  in   1   synchronous, active-high reset
//  i_req     in   1   I request; held with i_addr stable until i_valid
//  i_addr    in   AW  I fetch address
//  i_valid   out  1   one-cycle pulse: I transaction done, i_rdata valid
//  i_rdata   out  DW  I read data
//  d_req     in   1   D request; held with d_we/d_addr/d_wdata stable until d_valid
//  d_we      in   1   1 = write, 0 = read
//  d_addr    in   AW  D address
//  d_wdata   in   DW  D write data
//  d_valid   out  1   one-cycle pulse: D done (read data or write ack)
//  d_rdata   out  DW  D read data (0 on writes)
//  c_req     out  1   cache request, held high through BUSY
//  c_we      out  1   latched write enable
//  c_addr    out  AW  latched address
//  c_wdata   out  DW  latched write data
//  c_valid   in   1   cache done pulse, meaningful only in BUSY
//  c_rdata   in   DW  cache read data, qualified by c_valid
//  err       out  1   sticky: a watchdog abort occurred; cleared only by reset_in
//  err_src   out  1   requester of the most recent abort (0 = I, 1 = D)
// BEHAVIOUR
//  Reset: state=IDLE, last=I, c_req/c_we/c_addr/c_wdata=0, i_/d_valid=0, i_/d_rdata=0, err=0,
//   err_src=0, watchdog=0. Reset in BUSY drops c_req next edge; any later c_valid is ignored.
//  States: IDLE, BUSY. Register owner (I/D), last (last granted).
//  IDLE: eligible = req & ~(requester's valid high this cycle); the just-served requester is
//   masked for one cycle. One eligible -> grant it. Both eligible -> grant ~last
//   (after reset D wins first). Grant edge: latch addr/we/wdata (I: we=0, wdata=0) into c_*,
//   c_req=1, owner=winner, last=winner, watchdog=0, state=BUSY. None eligible -> stay, c_req=0.
//  BUSY: c_* held constant. c_valid=1 -> next edge: owner's valid=1, owner's rdata=c_rdata
//   (d_rdata=0 when c_we=1), c_req=0, state=IDLE. Otherwise watchdog+1.
//   A c_valid on the same edge the watchdog expires completes normally.
//  Watchdog: TIMEOUT!=0 and watchdog==TIMEOUT-1 with no c_valid -> next edge: owner's valid=1,
//   rdata=0, err=1, err_src=owner, c_req=0, state=IDLE.
//  valid outputs are single-cycle pulses; rdata holds its value until the next completion.
//  Latency: req seen in IDLE at edge N -> c_req high after edge N; c_valid at edge M -> valid
//   high after edge M. Min request-to-valid = 2 cycles when cache answers in one.
//  c_valid in IDLE ignored. req dropped mid-BUSY is a protocol violation; transaction still completes.
// TESTING
//  1 Reset, d_req read addr 0x40, cache returns 0xDEADBEEF 1 cycle after c_req -> c_addr=0x40,
//    c_we=0; d_valid one cycle with d_rdata=0xDEADBEEF, 2 cycles after d_req.
//  2 i_req and d_req both held from reset -> grant order D,I,D,I over 4 transactions; no
//    requester is granted twice in a row; c_req low exactly one cycle between grants.
//  3 d_req write addr 0x10 data 0x1234 -> c_we=1, c_wdata=0x1234 until c_valid; d_valid
//    pulse, d_rdata=0.
//  4 TIMEOUT=8, i_req, c_valid never asserted -> after 8 BUSY cycles i_valid pulse, i_rdata=0,
//    err=1, err_src=0; err stays 1 through further normal transactions until reset_in.
//  5 reset_in pulsed 3 cycles into BUSY, c_valid 2 cycles later -> c_req=0 after reset edge;
//    no i_/d_valid pulse; next request arbitrated from IDLE with D priority.
//  6 Requester holds req through its valid cycle, other idle -> no re-grant that cycle;
//    re-granted the following cycle (back-to-back reads with one idle cycle).

Source files
------------

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter
//   Shares one cache port between the instruction-fetch (I) and load/store (D)
//   requesters. Round-robin arbitration, the winning request is latched and held
//   on the cache port until the cache answers, and read data returns to the
//   owner as a one-cycle valid pulse. A watchdog aborts transactions the cache
//   never answers and flags them in a sticky error bit.
//
// Ports
//   phi, reset_in                  clock, synchronous active-high reset
//   i_req/i_addr                   I request (held until i_valid)
//   i_valid/i_rdata                I completion pulse and read data
//   d_req/d_we/d_addr/d_wdata      D request (held until d_valid)
//   d_valid/d_rdata                D completion pulse, read data (0 on writes)
//   c_req/c_we/c_addr/c_wdata      latched cache request
//   c_valid/c_rdata                cache completion, qualified in BUSY only
//   err/err_src                    sticky abort flag, requester of last abort
module cache_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          phi,
  input  logic          reset_in,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_valid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          c_req,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_wdata,
  input  logic          c_valid,
  input  logic [DW-1:0] c_rdata,
  output logic          err,
  output logic          err_src
);

  // Watchdog keeps at least one bit so a disabled watchdog still elaborates.
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  // Requester encoding for owner/last/err_src: 0 = I, 1 = D.
  state_t          state_q;
  logic            owner_q, last_q;
  logic [WDW-1:0]  wd_q;
  logic            c_req_q, c_we_q;
  logic [AW-1:0]   c_addr_q;
  logic [DW-1:0]   c_wdata_q;
  logic            i_valid_q, d_valid_q;
  logic [DW-1:0]   i_rdata_q, d_rdata_q;
  logic            err_q, err_src_q;

  // A requester whose valid is high this cycle is still holding req from the
  // finished transaction, so it sits out one arbitration round.
  logic i_elig, d_elig, gnt_d;
  always_comb begin
    i_elig = i_req & ~i_valid_q;
    d_elig = d_req & ~d_valid_q;
    gnt_d  = (i_elig & d_elig) ? ~last_q : d_elig;
  end

  always_ff @(posedge phi) begin
    if (reset_in) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      wd_q      <= '0;
      c_req_q   <= 1'b0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      err_src_q <= 1'b0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_elig | d_elig) begin
            state_q   <= BUSY;
            owner_q   <= gnt_d;
            last_q    <= gnt_d;
            wd_q      <= '0;
            c_req_q   <= 1'b1;
            c_we_q    <= gnt_d ? d_we : 1'b0;
            c_addr_q  <= gnt_d ? d_addr : i_addr;
            c_wdata_q <= gnt_d ? d_wdata : '0;
          end else begin
            c_req_q <= 1'b0;
          end
        end
        BUSY: begin
          // A cache answer wins over a watchdog expiry on the same edge.
          if (c_valid) begin
            state_q <= IDLE;
            c_req_q <= 1'b0;
            if (owner_q) begin
              d_valid_q <= 1'b1;
              d_rdata_q <= c_we_q ? '0 : c_rdata;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= c_rdata;
            end
          end else if (WD_EN && wd_q == WD_LAST) begin
            state_q   <= IDLE;
            c_req_q   <= 1'b0;
            err_q     <= 1'b1;
            err_src_q <= owner_q;
            if (owner_q) begin
              d_valid_q <= 1'b1;
              d_rdata_q <= '0;
            end else begin
              i_valid_q <= 1'b1;
              i_rdata_q <= '0;
            end
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_valid = i_valid_q;
  assign i_rdata = i_rdata_q;
  assign d_valid = d_valid_q;
  assign d_rdata = d_rdata_q;
  assign c_req   = c_req_q;
  assign c_we    = c_we_q;
  assign c_addr  = c_addr_q;
  assign c_wdata = c_wdata_q;
  assign err     = err_q;
  assign err_src = err_src_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
module tb_cache_port_arbiter;
  localparam int AW = 32, DW = 32, TO = 8;
  localparam logic H = 1'b1, L = 1'b0;

  logic phi = 1'b0;
  always #5 phi = ~phi;

  logic reset_in = 1'b1;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, c_valid = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, c_rdata = '0;
  logic i_valid, d_valid, c_req, c_we, err, err_src;
  logic [DW-1:0] i_rdata, d_rdata, c_wdata;
  logic [AW-1:0] c_addr;

  cache_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .phi(phi), .reset_in(reset_in),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_valid(c_valid), .c_rdata(c_rdata), .err(err), .err_src(err_src));

  int n_chk = 0, n_fail = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs are then redriven.
  task automatic step();
    @(posedge phi);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; c_valid = 1'b0;
    step();
    reset_in = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, ireq, dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic cv;
    logic [31:0] crd;
    logic ecreq, ecwe;
    logic [31:0] ecaddr, ecwdata;
    logic eiv, edv;
    logic [31:0] eird, edrd;
  } vec_t;

  function automatic vec_t mk(input logic rst, ireq, dreq, dwe,
                              input logic [31:0] daddr, dwdata,
                              input logic cv, input logic [31:0] crd,
                              input logic ecreq, ecwe,
                              input logic [31:0] ecaddr, ecwdata,
                              input logic eiv, edv,
                              input logic [31:0] eird, edrd);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.dreq = dreq; v.dwe = dwe;
    v.daddr = daddr; v.dwdata = dwdata; v.cv = cv; v.crd = crd;
    v.ecreq = ecreq; v.ecwe = ecwe; v.ecaddr = ecaddr; v.ecwdata = ecwdata;
    v.eiv = eiv; v.edv = edv; v.eird = eird; v.edrd = edrd;
    return v;
  endfunction

  vec_t tbl[20];

  // ---------------- reference model for random phase ----------------
  logic m_busy, m_owner, m_last, m_we, m_err, m_esrc, m_iv, m_dv;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  int m_wd;

  task automatic mdl_reset();
    m_busy = 0; m_owner = 0; m_last = 0; m_we = 0; m_err = 0; m_esrc = 0;
    m_iv = 0; m_dv = 0; m_addr = 0; m_wdata = 0; m_ird = 0; m_drd = 0; m_wd = 0;
  endtask

  // One clock edge of the spec's behaviour, using the inputs held across it.
  task automatic mdl_step();
    logic ie, de, w, niv, ndv;
    niv = 0; ndv = 0;
    if (reset_in) begin
      mdl_reset();
      return;
    end
    if (!m_busy) begin
      ie = i_req && !m_iv;
      de = d_req && !m_dv;
      if (ie || de) begin
        w = (ie && de) ? !m_last : de;
        m_busy = 1; m_owner = w; m_last = w; m_wd = 0;
        if (w) begin m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; end
        else   begin m_we = 0;    m_addr = i_addr; m_wdata = 0;       end
      end
    end else if (c_valid) begin
      m_busy = 0;
      if (m_owner) begin ndv = 1; m_drd = m_we ? 32'h0 : c_rdata; end
      else         begin niv = 1; m_ird = c_rdata; end
    end else if (m_wd == TO - 1) begin
      m_busy = 0; m_err = 1; m_esrc = m_owner;
      if (m_owner) begin ndv = 1; m_drd = 0; end
      else         begin niv = 1; m_ird = 0; end
    end else begin
      m_wd++;
    end
    m_iv = niv; m_dv = ndv;
  endtask

  initial begin
    bit r_act;
    int r_n, r_lat;

    tbl[0]  = mk(L,L,H,L, 32'h40,0,       L,0,            H,L,32'h40,0,       L,L,0,0);
    tbl[1]  = mk(L,L,H,L, 32'h40,0,       H,32'hDEADBEEF, L,L,0,0,            L,H,0,32'hDEADBEEF);
    tbl[2]  = mk(L,L,L,L, 0,0,            L,0,            L,L,0,0,            L,L,0,32'hDEADBEEF);
    tbl[3]  = mk(L,L,H,H, 32'h10,32'h1234,L,0,            H,H,32'h10,32'h1234,L,L,0,32'hDEADBEEF);
    tbl[4]  = mk(L,L,H,H, 32'h10,32'h1234,L,0,            H,H,32'h10,32'h1234,L,L,0,32'hDEADBEEF);
    tbl[5]  = mk(L,L,H,H, 32'h10,32'h1234,H,32'hFFFF0000, L,L,0,0,            L,H,0,0);
    tbl[6]  = mk(L,L,H,L, 32'h44,0,       L,0,            L,L,0,0,            L,L,0,0);
    tbl[7]  = mk(L,L,H,L, 32'h44,0,       H,32'hCAFEF00D, H,L,32'h44,0,       L,L,0,0);
    tbl[8]  = mk(L,L,H,L, 32'h44,0,       H,32'hCAFEF00D, L,L,0,0,            L,H,0,32'hCAFEF00D);
    tbl[9]  = mk(L,L,L,L, 0,0,            L,0,            L,L,0,0,            L,L,0,32'hCAFEF00D);
    tbl[10] = mk(H,L,L,L, 0,0,            L,0,            L,L,0,0,            L,L,0,0);
    tbl[11] = mk(L,H,H,L, 32'h80,0,       L,0,            H,L,32'h80,0,       L,L,0,0);
    tbl[12] = mk(L,H,H,L, 32'h80,0,       H,32'h11111111, L,L,0,0,            L,H,0,32'h11111111);
    tbl[13] = mk(L,H,H,L, 32'h80,0,       L,0,            H,L,32'h200,0,      L,L,0,32'h11111111);
    tbl[14] = mk(L,H,H,L, 32'h80,0,       H,32'h22222222, L,L,0,0,            H,L,32'h22222222,32'h11111111);
    tbl[15] = mk(L,H,H,L, 32'h80,0,       L,0,            H,L,32'h80,0,       L,L,32'h22222222,32'h11111111);
    tbl[16] = mk(L,H,H,L, 32'h80,0,       H,32'h33333333, L,L,0,0,            L,H,32'h22222222,32'h33333333);
    tbl[17] = mk(L,H,H,L, 32'h80,0,       L,0,            H,L,32'h200,0,      L,L,32'h22222222,32'h33333333);
    tbl[18] = mk(L,H,H,L, 32'h80,0,       H,32'h00000044, L,L,0,0,            H,L,32'h44,32'h33333333);
    tbl[19] = mk(L,L,L,L, 0,0,            L,0,            L,L,0,0,            L,L,32'h44,32'h33333333);

    // reset state
    step(); step();
    chk1("rst c_req", c_req, 1'b0);       chk1("rst c_we", c_we, 1'b0);
    chk32("rst c_addr", c_addr, 32'h0);   chk32("rst c_wdata", c_wdata, 32'h0);
    chk1("rst i_valid", i_valid, 1'b0);   chk1("rst d_valid", d_valid, 1'b0);
    chk32("rst i_rdata", i_rdata, 32'h0); chk32("rst d_rdata", d_rdata, 32'h0);
    chk1("rst err", err, 1'b0);           chk1("rst err_src", err_src, 1'b0);
    reset_in = 1'b0;

    // table: basic read, write, back-to-back masking, reset + D-first alternation
    for (int k = 0; k < 20; k++) begin
      reset_in = tbl[k].rst; i_req = tbl[k].ireq; i_addr = 32'h200;
      d_req = tbl[k].dreq; d_we = tbl[k].dwe; d_addr = tbl[k].daddr; d_wdata = tbl[k].dwdata;
      c_valid = tbl[k].cv; c_rdata = tbl[k].crd;
      step();
      chk1($sformatf("vec%0d c_req", k), c_req, tbl[k].ecreq);
      if (tbl[k].ecreq) begin
        chk1($sformatf("vec%0d c_we", k), c_we, tbl[k].ecwe);
        chk32($sformatf("vec%0d c_addr", k), c_addr, tbl[k].ecaddr);
        chk32($sformatf("vec%0d c_wdata", k), c_wdata, tbl[k].ecwdata);
      end
      chk1($sformatf("vec%0d i_valid", k), i_valid, tbl[k].eiv);
      chk1($sformatf("vec%0d d_valid", k), d_valid, tbl[k].edv);
      chk32($sformatf("vec%0d i_rdata", k), i_rdata, tbl[k].eird);
      chk32($sformatf("vec%0d d_rdata", k), d_rdata, tbl[k].edrd);
      chk1($sformatf("vec%0d err", k), err, 1'b0);
    end

    // watchdog: normal I read, then an unanswered I read aborts after 8 BUSY cycles
    do_reset();
    i_req = 1'b1; i_addr = 32'h300; step();
    c_valid = 1'b1; c_rdata = 32'h0000ABCD; step();
    chk32("wd pre i_rdata", i_rdata, 32'h0000ABCD);
    c_valid = 1'b0; step();
    step();
    chk1("wd grant c_req", c_req, 1'b1);
    for (int k = 1; k < TO; k++) begin
      step();
      chk1($sformatf("wd busy%0d c_req", k), c_req, 1'b1);
      chk1($sformatf("wd busy%0d i_valid", k), i_valid, 1'b0);
    end
    step();
    chk1("wd abort i_valid", i_valid, 1'b1); chk32("wd abort i_rdata", i_rdata, 32'h0);
    chk1("wd abort err", err, 1'b1);         chk1("wd abort err_src", err_src, 1'b0);
    chk1("wd abort c_req", c_req, 1'b0);
    i_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; step();
    chk1("wd sticky grant err", err, 1'b1);
    c_valid = 1'b1; step();
    chk1("wd sticky d_valid", d_valid, 1'b1); chk1("wd sticky err", err, 1'b1);
    chk1("wd sticky err_src", err_src, 1'b0);
    c_valid = 1'b0; d_req = 1'b0; step();
    d_req = 1'b1; d_we = 1'b0; step();
    for (int k = 0; k < TO; k++) step();
    chk1("wd d abort d_valid", d_valid, 1'b1); chk32("wd d abort d_rdata", d_rdata, 32'h0);
    chk1("wd d abort err_src", err_src, 1'b1);
    d_req = 1'b0;
    do_reset();
    chk1("wd cleared err", err, 1'b0);

    // reset in BUSY: late c_valid ignored, next arbitration gives D priority
    i_req = 1'b1; i_addr = 32'h500; step();
    chk32("rb grant c_addr", c_addr, 32'h500);
    step(); step();
    reset_in = 1'b1; step();
    chk1("rb c_req", c_req, 1'b0);
    reset_in = 1'b0; i_req = 1'b0; step();
    chk1("rb i_valid a", i_valid, 1'b0);
    c_valid = 1'b1; c_rdata = 32'h99; step();
    chk1("rb i_valid b", i_valid, 1'b0); chk1("rb d_valid b", d_valid, 1'b0);
    chk1("rb c_req b", c_req, 1'b0);
    c_valid = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; step();
    chk1("rb regrant c_req", c_req, 1'b1); chk32("rb regrant c_addr", c_addr, 32'h600);
    c_valid = 1'b1; c_rdata = 32'h77; step();
    chk1("rb d_valid", d_valid, 1'b1); chk32("rb d_rdata", d_rdata, 32'h77);
    c_valid = 1'b0; i_req = 1'b0; d_req = 1'b0;

    // randomized run against the reference model
    do_reset();
    mdl_reset();
    r_act = 0; r_n = 0; r_lat = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset_in = ($urandom_range(0, 299) == 0);
      if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
      end else if (i_valid) begin
        if ($urandom_range(0, 1) == 0) i_addr = $urandom; else i_req = 1'b0;
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
        end
      end else if (d_valid) begin
        if ($urandom_range(0, 1) == 0) begin
          d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1) == 1;
        end else d_req = 1'b0;
      end
      if (c_req) begin
        if (!r_act) begin
          r_act = 1; r_n = 0;
          r_lat = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
        end
        c_valid = (r_n == r_lat);
        r_n++;
      end else begin
        r_act = 0;
        c_valid = ($urandom_range(0, 7) == 0);
      end
      c_rdata = $urandom;
      step();
      mdl_step();
      chk1("rnd c_req", c_req, m_busy);
      if (m_busy) begin
        chk1("rnd c_we", c_we, m_we);
        chk32("rnd c_addr", c_addr, m_addr);
        chk32("rnd c_wdata", c_wdata, m_wdata);
      end
      chk1("rnd i_valid", i_valid, m_iv);
      chk1("rnd d_valid", d_valid, m_dv);
      chk32("rnd i_rdata", i_rdata, m_ird);
      chk32("rnd d_rdata", d_rdata, m_drd);
      chk1("rnd err", err, m_err);
      chk1("rnd err_src", err_src, m_esrc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
